// File: rtl/param_universal_shift_register.sv
// Parametrised universal shift register: barrel shift/rotate/load plus an autonomous LSB-first serialiser.
// Latency: every operation completes in one clock; a burst occupies WIDTH busy cycles, then a one-cycle done pulse.
// Backpressure: none; en/mode/shamt/d are ignored while busy, and a new burst may start in the done cycle.
module param_universal_shift_register #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q,
  output logic             sout_lsb,
  output logic             sout_msb,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  // The bit counter has to hold the value WIDTH itself, hence one extra bit.
  localparam int CW = SHW + 1;
  localparam logic [CW-1:0]    CNT_FIRST = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(WIDTH);
  localparam logic [WIDTH-1:0] ONES      = '1;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_BURST = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  // Complementary amount (WIDTH - shamt) mod WIDTH; WIDTH is a power of two so wrap-around does it.
  logic [SHW-1:0]   inv_shamt;
  logic [WIDTH-1:0] shl_res;
  logic [WIDTH-1:0] shr_res;
  logic [WIDTH-1:0] asr_res;
  logic [WIDTH-1:0] rol_res;
  logic [WIDTH-1:0] ror_res;

  // Single-cycle barrel results for every shift/rotate mode; shamt=0 falls out as identity.
  always_comb begin
    inv_shamt = {SHW{1'b0}} - shamt;
    shl_res   = (q_q << shamt) | (sin_lsb  ? ~(ONES << shamt) : '0);
    shr_res   = (q_q >> shamt) | (sin_msb  ? ~(ONES >> shamt) : '0);
    asr_res   = (q_q >> shamt) | (q_q[WIDTH-1] ? ~(ONES >> shamt) : '0);
    rol_res   = (q_q << shamt) | (q_q >> inv_shamt);
    ror_res   = (q_q >> shamt) | (q_q << inv_shamt);
  end

  // Next-state: idle applies the selected op when enabled; burst shifts right and counts WIDTH edges.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          case (mode_e'(mode))
            MODE_HOLD:  q_d = q_q;
            MODE_SHL:   q_d = shl_res;
            MODE_SHR:   q_d = shr_res;
            MODE_LOAD:  q_d = d;
            MODE_ROL:   q_d = rol_res;
            MODE_ROR:   q_d = ror_res;
            MODE_ASR:   q_d = asr_res;
            MODE_BURST: begin
              q_d     = d;
              state_d = ST_BURST;
              cnt_d   = CNT_FIRST;
            end
            default:    q_d = q_q;
          endcase
        end
      end
      ST_BURST: begin
        q_d = {sin_msb, q_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_FIRST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; synchronous reset aborts any burst without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Outputs depend only on registered state.
  assign q        = q_q;
  assign sout_lsb = q_q[0];
  assign sout_msb = q_q[WIDTH-1];
  assign busy     = (state_q == ST_BURST);
  assign done     = done_q;
  assign zero     = (q_q == '0);

endmodule

// File: doc/param_universal_shift_register.md
Name: param_universal_shift_register

Overview:
- Parametrised next-generation universal shift register for the register library.
- Adds configurable width, multi-bit shift amount, rotate and arithmetic modes, a clock enable, and an autonomous serialiser (burst) mode with busy/done handshake.
- Used as the datapath shifter/serialiser feeding serial links and ALU test harnesses.

Parameters:
- WIDTH, 8, register width in bits; legal range 4..64, power of two.
- SHW, $clog2(WIDTH), width of shift-amount input; derived, not overridden.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  operation enable; ignored while busy.
- mode  input  3  operation select (see Behaviour).
- shamt  input  SHW  shift/rotate amount, 0..WIDTH-1.
- d  input  WIDTH  parallel load data.
- sin_lsb  input  1  fill bit for left shifts.
- sin_msb  input  1  fill bit for logical right shifts and burst.
- q  output  WIDTH  register contents.
- sout_lsb  output  1  equals q[0]; serial stream in burst.
- sout_msb  output  1  equals q[WIDTH-1].
- busy  output  1  high while burst in progress.
- done  output  1  one-cycle pulse at burst completion.
- zero  output  1  combinational, q == 0.

Behaviour:
- Reset: rst=1 at rising edge -> q=0, busy=0, done=0, internal bit counter=0; overrides everything, including mid-burst (burst aborted, no done pulse).
- done defaults to 0 every cycle unless set as below.
- When not busy and en=0: q holds, regardless of mode.
- When not busy and en=1, on rising edge, by mode:
  - 000 hold: q unchanged.
  - 001 shift left by shamt; vacated low bits all = sin_lsb.
  - 010 logical shift right by shamt; vacated high bits all = sin_msb.
  - 011 parallel load: q <= d.
  - 100 rotate left by shamt.
  - 101 rotate right by shamt.
  - 110 arithmetic shift right by shamt; vacated bits = old q[WIDTH-1].
  - 111 burst start: q <= d, busy <= 1, counter <= 1.
- shamt=0 in any shift/rotate mode: q unchanged. All shifts are single-cycle (barrel); shamt never exceeds WIDTH-1 by construction.
- Burst operation (busy=1), each rising edge:
  - q <= {sin_msb, q[WIDTH-1:1]}.
  - If counter == WIDTH: busy <= 0, done <= 1, counter <= 0; otherwise counter increments.
- Burst timing: the cycle after the start edge, sout_lsb = d[0]. Each following cycle presents d[1]..d[WIDTH-1]. busy stays high for exactly WIDTH cycles.
- The final edge performs one more shift, clears busy and pulses done. Afterwards q holds the WIDTH sin_msb samples, with the earliest sample in the LSB.
- en, mode, shamt and d are ignored while busy. A new burst may start on the first edge after busy falls, i.e. while done is high.
- Counter width is $clog2(WIDTH)+1.
- zero, sout_lsb and sout_msb are combinational from q only; no input-to-output combinational path.

Test Plan:
- Reset/load/hold (WIDTH=8): rst=1 -> q=0x00, zero=1, busy=0. Then en=1, mode=011, d=0xA5 -> q=0xA5. Then mode=000 for 3 cycles -> q=0xA5. Then en=0, mode=011, d=0xFF -> q stays 0xA5.
- Shifts: q=0x96, mode=001, shamt=3, sin_lsb=1 -> q=0xB7. From 0x96, mode=010, shamt=2, sin_msb=0 -> q=0x25. From 0x96, mode=110, shamt=3 -> q=0xF2. shamt=0 in any shift mode -> q unchanged.
- Rotates: q=0x81, mode=100, shamt=1 -> q=0x03. From 0x81, mode=101, shamt=4 -> q=0x18. From 0x81, 8 successive rotate-left by 1 -> returns to 0x81.
- Burst: mode=111, d=0x5C, sin_msb=1. sout_lsb over the next 8 cycles = 0,0,1,1,1,0,1,0 with busy=1. Then done=1 for one cycle, busy=0, q=0xFF. mode/d toggled mid-burst have no effect.
- Reset mid-burst: start burst with d=0xF0, assert rst on the 4th busy cycle -> q=0x00, busy=0, done never asserts. Next edge with mode=011, d=0x3C -> q=0x3C.
- Back-to-back bursts: assert mode=111, en=1 in the done cycle with d=0x01 -> second burst starts immediately. The first sout_lsb of the second burst = 1, with no idle cycle between the bursts.
